// File: rtl/sha256_digest_streamer_if.sv
// Byte stream carrying a serialised digest from the streamer to its sink.
interface sha256_digest_streamer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/sha256_digest_streamer.sv
// Serialises a 256-bit SHA-256 digest onto a valid/ready byte stream,
// either as 32 raw bytes or as 64 lowercase ASCII hex characters.
// A rising edge of hash_done captures a new digest; replay resends the
// last captured one. All stream outputs come straight from flops.
module sha256_digest_streamer #(
  parameter int HEX_MODE = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [255:0]                    hash_in,
  input  logic                            hash_done,
  input  logic                            replay,
  sha256_digest_streamer_if.master        stream,
  output logic                            busy
);

  localparam logic [5:0] LAST_IDX = (HEX_MODE != 0) ? 6'd63 : 6'd31;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t       state;
  state_t       state_next;
  logic         done_prev;
  logic         done_rise;
  logic         valid_digest;
  logic         valid_digest_next;
  logic [255:0] holding;
  logic [255:0] holding_next;
  logic [5:0]   beat_cnt;
  logic [5:0]   beat_next;
  logic [5:0]   beat_inc;
  logic [7:0]   data_q;
  logic [7:0]   data_next;
  logic         valid_q;
  logic         valid_next;
  logic         last_q;
  logic         last_next;

  // Symbol emitted for a given beat: a raw byte, or one hex character
  // (high nibble on even beats, low nibble on odd beats).
  function automatic logic [7:0] symbol_at(input logic [255:0] digest,
                                           input logic [5:0]   idx);
    logic [4:0]   byte_idx;
    logic [255:0] shifted;
    logic [7:0]   byte_val;
    logic [3:0]   nib;
    byte_idx = (HEX_MODE != 0) ? idx[5:1] : idx[4:0];
    shifted  = digest << {byte_idx, 3'b000};
    byte_val = shifted[255:248];
    nib      = idx[0] ? byte_val[3:0] : byte_val[7:4];
    if (HEX_MODE == 0) begin
      return byte_val;
    end
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h57 + {4'h0, nib};
  endfunction

  assign done_rise = hash_done & ~done_prev;
  assign beat_inc  = beat_cnt + 6'd1;

  // Next-state and next-output logic; only a fresh rising edge of hash_done
  // or a replay of an already captured digest can start a transmission.
  always_comb begin
    state_next        = state;
    valid_digest_next = valid_digest;
    holding_next      = holding;
    beat_next         = beat_cnt;
    data_next         = data_q;
    valid_next        = valid_q;
    last_next         = last_q;
    case (state)
      IDLE: begin
        if (done_rise) begin
          holding_next      = hash_in;
          valid_digest_next = 1'b1;
          beat_next         = 6'd0;
          data_next         = symbol_at(hash_in, 6'd0);
          valid_next        = 1'b1;
          last_next         = 1'b0;
          state_next        = SEND;
        end else if (replay && valid_digest) begin
          beat_next  = 6'd0;
          data_next  = symbol_at(holding, 6'd0);
          valid_next = 1'b1;
          last_next  = 1'b0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (stream.out_ready) begin
          if (beat_cnt == LAST_IDX) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            state_next = IDLE;
          end else begin
            beat_next = beat_inc;
            data_next = symbol_at(holding, beat_inc);
            last_next = (beat_inc == LAST_IDX);
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
      end
    endcase
  end

  // State, digest holding register and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      done_prev    <= 1'b0;
      valid_digest <= 1'b0;
      holding      <= '0;
      beat_cnt     <= 6'd0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state        <= state_next;
      done_prev    <= hash_done;
      valid_digest <= valid_digest_next;
      holding      <= holding_next;
      beat_cnt     <= beat_next;
      data_q       <= data_next;
      valid_q      <= valid_next;
      last_q       <= last_next;
    end
  end

  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;
  assign stream.out_last  = last_q;
  assign busy             = (state == SEND);

endmodule

// File: tb/tb_sha256_digest_streamer.sv
// Bench for sha256_digest_streamer: a raw and a hex instance share the
// digest inputs and are checked against a string/arithmetic reference model.
module tb_sha256_digest_streamer;

  typedef logic [7:0] byte_q_t[$];
  typedef logic       bit_q_t[$];

  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk;
  logic         rst;
  logic [255:0] hash_in;
  logic         hash_done;
  logic         replay;
  logic         busy_r;
  logic         busy_h;
  logic         rand_ready;

  sha256_digest_streamer_if if_r ();
  sha256_digest_streamer_if if_h ();

  sha256_digest_streamer #(.HEX_MODE(0)) u_raw (
    .clk       (clk),
    .rst       (rst),
    .hash_in   (hash_in),
    .hash_done (hash_done),
    .replay    (replay),
    .stream    (if_r),
    .busy      (busy_r)
  );

  sha256_digest_streamer #(.HEX_MODE(1)) u_hex (
    .clk       (clk),
    .rst       (rst),
    .hash_in   (hash_in),
    .hash_done (hash_done),
    .replay    (replay),
    .stream    (if_h),
    .busy      (busy_h)
  );

  int      vectors;
  int      miscompares;
  byte_q_t got_r;
  byte_q_t got_h;
  bit_q_t  last_r;
  bit_q_t  last_h;
  int      busy_cnt_r;
  int      busy_cnt_h;
  bit      stall_prev;
  logic [7:0] stall_data;
  logic    stall_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: raw bytes by arithmetic, hex characters by formatting.
  task automatic buildExpected(input logic [255:0] d, input bit hex, output byte_q_t q);
    string s;
    logic [255:0] sh;
    q = {};
    if (hex) begin
      s = $sformatf("%h", d);
      for (int i = 0; i < 64; i++) q.push_back(s[i]);
    end else begin
      for (int i = 0; i < 32; i++) begin
        sh = d >> (8 * (31 - i));
        q.push_back(sh[7:0]);
      end
    end
  endtask

  task automatic checkDigest(input string tag, input logic [255:0] d, input bit hex,
                             input byte_q_t got, input bit_q_t lasts);
    byte_q_t exp;
    buildExpected(d, hex, exp);
    checkOutput({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checkOutput($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
      checkOutput($sformatf("%s_last%0d", tag, i), lasts[i], (i == exp.size() - 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearCapture();
    got_r.delete();
    got_h.delete();
    last_r.delete();
    last_h.delete();
    busy_cnt_r = 0;
    busy_cnt_h = 0;
  endtask

  task automatic applyStimulus(input logic [255:0] d, input int hold);
    hash_in   = d;
    hash_done = 1'b1;
    repeat (hold) tick();
    hash_done = 1'b0;
  endtask

  task automatic drain();
    bit done_ok;
    done_ok = 1'b0;
    for (int i = 0; i < 1000 && !done_ok; i++) begin
      tick();
      if (!busy_r && !busy_h && !if_r.out_valid && !if_h.out_valid) done_ok = 1'b1;
    end
    if (!done_ok) checkOutput("drain_timeout", 0, 1);
  endtask

  // Sink readiness: held high, or randomised after each edge for backpressure.
  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      if_r.out_ready = 1'($urandom_range(0, 1));
      if_h.out_ready = 1'($urandom_range(0, 1));
    end else begin
      if_r.out_ready = 1'b1;
      if_h.out_ready = 1'b1;
    end
  end

  // Monitor: records accepted beats, counts busy cycles, checks stall stability.
  always @(negedge clk) begin
    if ((if_r.out_valid & if_r.out_ready) === 1'b1) begin
      got_r.push_back(if_r.out_data);
      last_r.push_back(if_r.out_last);
    end
    if ((if_h.out_valid & if_h.out_ready) === 1'b1) begin
      got_h.push_back(if_h.out_data);
      last_h.push_back(if_h.out_last);
    end
    if (busy_r === 1'b1) busy_cnt_r++;
    if (busy_h === 1'b1) busy_cnt_h++;
    if (stall_prev && if_r.out_valid === 1'b1) begin
      checkOutput("stall_data", if_r.out_data, stall_data);
      checkOutput("stall_last", if_r.out_last, stall_last);
    end
    stall_prev = (if_r.out_valid === 1'b1) && (if_r.out_ready === 1'b0);
    stall_data = if_r.out_data;
    stall_last = if_r.out_last;
  end

  initial begin
    logic [255:0] d;
    logic [255:0] d2;
    bit           hit;
    int           n;
    vectors     = 0;
    miscompares = 0;
    stall_prev  = 1'b0;
    rand_ready  = 1'b0;
    rst         = 1'b1;
    hash_done   = 1'b0;
    replay      = 1'b0;
    hash_in     = '0;
    clearCapture();
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_valid_r", if_r.out_valid, 0);
    checkOutput("rst_last_r", if_r.out_last, 0);
    checkOutput("rst_data_r", if_r.out_data, 0);
    checkOutput("rst_busy_r", busy_r, 0);
    checkOutput("rst_valid_h", if_h.out_valid, 0);
    checkOutput("rst_busy_h", busy_h, 0);
    tick();
    rst = 1'b0;
    tick();

    // Empty-message digest, no backpressure.
    clearCapture();
    applyStimulus(EMPTY_DIGEST, 1);
    drain();
    checkDigest("empty_raw", EMPTY_DIGEST, 0, got_r, last_r);
    checkDigest("empty_hex", EMPTY_DIGEST, 1, got_h, last_h);
    checkOutput("raw_first", got_r[0], 8'he3);
    checkOutput("raw_second", got_r[1], 8'hb0);
    checkOutput("raw_final", got_r[31], 8'h55);
    checkOutput("raw_final_last", last_r[31], 1);
    checkOutput("raw_busy_cycles", busy_cnt_r, 32);
    checkOutput("hex_c0", got_h[0], 8'h65);
    checkOutput("hex_c1", got_h[1], 8'h33);
    checkOutput("hex_c2", got_h[2], 8'h62);
    checkOutput("hex_c3", got_h[3], 8'h30);
    checkOutput("hex_c62", got_h[62], 8'h35);
    checkOutput("hex_c63", got_h[63], 8'h35);
    checkOutput("hex_c63_last", last_h[63], 1);
    checkOutput("hex_busy_cycles", busy_cnt_h, 64);

    // Random digests under random backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      clearCapture();
      applyStimulus(d, 1);
      drain();
      checkDigest($sformatf("bp%0d_raw", k), d, 0, got_r, last_r);
      checkDigest($sformatf("bp%0d_hex", k), d, 1, got_h, last_h);
    end
    rand_ready = 1'b0;
    tick();

    // hash_done held high produces a single digest.
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    clearCapture();
    applyStimulus(d, 200);
    drain();
    checkDigest("held_raw", d, 0, got_r, last_r);
    checkDigest("held_hex", d, 1, got_h, last_h);

    // Replay from IDLE resends the same digest.
    clearCapture();
    replay = 1'b1;
    tick();
    replay = 1'b0;
    drain();
    checkDigest("replay_raw", d, 0, got_r, last_r);
    checkDigest("replay_hex", d, 1, got_h, last_h);

    // A second replay while sending has no effect.
    clearCapture();
    replay = 1'b1;
    tick();
    replay = 1'b0;
    repeat (5) tick();
    replay = 1'b1;
    tick();
    replay = 1'b0;
    drain();
    checkDigest("replay_send_raw", d, 0, got_r, last_r);
    checkDigest("replay_send_hex", d, 1, got_h, last_h);

    // New hash_done edge mid-stream is ignored.
    d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d2 = ~d;
    clearCapture();
    applyStimulus(d, 1);
    repeat (8) tick();
    applyStimulus(d2, 2);
    drain();
    checkDigest("busy_edge_raw", d, 0, got_r, last_r);
    checkDigest("busy_edge_hex", d, 1, got_h, last_h);

    // Reset mid-stream aborts, then replay is refused.
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    clearCapture();
    applyStimulus(d, 1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (got_r.size() >= 11) hit = 1'b1;
    end
    if (!hit) checkOutput("beat10_timeout", 0, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid_r", if_r.out_valid, 0);
    checkOutput("abort_valid_h", if_h.out_valid, 0);
    checkOutput("abort_data_r", if_r.out_data, 0);
    checkOutput("abort_busy_r", busy_r, 0);
    n = got_r.size();
    repeat (5) tick();
    replay = 1'b1;
    tick();
    replay = 1'b0;
    repeat (10) tick();
    checkOutput("abort_no_beats", got_r.size(), n);
    checkOutput("abort_replay_busy", busy_r, 0);
    checkOutput("abort_replay_valid", if_r.out_valid, 0);

    // hash_done already high at reset release starts a transmission.
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    clearCapture();
    rst       = 1'b1;
    hash_in   = d;
    hash_done = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("post_rst_start", busy_r, 1);
    hash_done = 1'b0;
    drain();
    checkDigest("post_rst_raw", d, 0, got_r, last_r);
    checkDigest("post_rst_hex", d, 1, got_h, last_h);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha256_digest_streamer.md
SHA256_DIGEST_STREAMER -- requirements
Module: sha256_digest_streamer

Interface
REQ-001 The block SHALL have the parameter HEX_MODE, default 0: 0 = raw binary, 32 bytes per digest; 1 = lowercase ASCII hex, 64 characters per digest.
REQ-002 The block SHALL have the port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have the port hash_in, input, 256 bits: digest from the hash processor; bits [255:248] are digest byte 0.
REQ-005 The block SHALL have the port hash_done, input, 1 bit: level from the processor; stays high while the digest is valid.
REQ-006 The block SHALL have the port replay, input, 1 bit: one-cycle pulse requesting retransmission of the last captured digest.
REQ-007 The block SHALL have the port out_data, output, 8 bits: current byte or character.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: out_data is valid.
REQ-009 The block SHALL have the port out_ready, input, 1 bit: the sink accepts a beat when out_valid and out_ready are both high.
REQ-010 The block SHALL have the port out_last, output, 1 bit: high with the final beat of a digest.
REQ-011 The block SHALL have the port busy, output, 1 bit: high while in state SEND.

Function
REQ-012 The block SHALL have the states IDLE and SEND, with a registered done_prev tracking hash_done.
REQ-013 In IDLE, when hash_done=1 and done_prev=0 at a clock edge, the block SHALL do all of the following on that edge: capture hash_in into a 256-bit holding register, clear beat_cnt, and enter SEND. out_valid is high from the next cycle.
REQ-014 In IDLE, when replay=1, valid_digest=1 and no rising edge of hash_done is present, the block SHALL enter SEND with beat_cnt=0 and leave the holding register unchanged.
REQ-015 In IDLE, a rising edge of hash_done SHALL take priority over a simultaneous replay.
REQ-016 replay while valid_digest=0 SHALL be ignored.
REQ-017 valid_digest SHALL be set on the first capture and cleared only by reset.
REQ-018 hash_done held high SHALL cause exactly one transmission; a new transmission requires hash_done to go low and then high again.
REQ-019 In SEND, a rising edge of hash_done SHALL be ignored: no capture and no queueing. done_prev SHALL still update every cycle.
REQ-020 In SEND, replay SHALL be ignored.
REQ-021 In SEND, out_valid SHALL be 1. A beat SHALL complete on every edge where out_ready=1, and beat_cnt SHALL increment on each completed beat.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-023 out_data, out_valid and out_last SHALL be registered outputs.
REQ-024 With HEX_MODE=0, out_data SHALL be holding[255-8*beat_cnt -: 8] for beat_cnt 0..31.
REQ-025 With HEX_MODE=1, beat_cnt runs 0..63. The nibble SHALL be byte (beat_cnt>>1), with the high nibble on even beats and the low nibble on odd beats.
REQ-026 With HEX_MODE=1, nibbles 0-9 SHALL map to 0x30-0x39 and nibbles 10-15 to 0x61-0x66.
REQ-027 out_last SHALL be 1 exactly when beat_cnt equals the final index (31 for raw, 63 for hex).
REQ-028 When the final beat is accepted, the block SHALL return to IDLE, with out_valid=0 and out_last=0 from the next cycle.
REQ-029 There SHALL be no wait cycles inside a digest: with out_ready held at 1, a digest takes exactly 32 (raw) or 64 (hex) consecutive cycles.
REQ-030 beat_cnt SHALL be 6 bits and SHALL never exceed the final index; it must not wrap within a digest.
REQ-031 After the final beat, the earliest next out_valid SHALL be two cycles later: one cycle in IDLE, then the trigger edge.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL set: state=IDLE, out_valid=0, out_last=0, out_data=0x00, busy=0, beat_cnt=0, done_prev=0, valid_digest=0, holding=0.
REQ-033 Reset asserted mid-digest SHALL abort the digest immediately, with no further beats.
REQ-034 If hash_done is already high when rst is released, the block SHALL see it as a rising edge on the first edge after reset and start a transmission.

Verification
REQ-035 The bench SHALL cover the raw empty-message digest: HEX_MODE=0, hash_in=e3b0c442...7852b855, hash_done rises, out_ready=1 -> 32 beats; first 0xe3, second 0xb0, last 0x55 with out_last=1; busy high for exactly 32 cycles.
REQ-036 The bench SHALL cover hex mode: HEX_MODE=1, same digest -> 64 beats; first beats 0x65 ('e'), 0x33 ('3'), 0x62 ('b'), 0x30 ('0'); last two beats 0x35 0x35 with out_last on the 64th beat.
REQ-037 The bench SHALL cover backpressure: out_ready toggled pseudo-randomly -> the byte sequence matches the no-stall case, and out_data is stable across every stalled cycle.
REQ-038 The bench SHALL cover held done and replay: hash_done held high for 200 cycles -> a single 32-beat digest. replay pulsed in IDLE -> an identical digest resent. replay pulsed during SEND -> no effect.
REQ-039 The bench SHALL cover reset mid-stream: rst for one cycle after beat 10 -> out_valid=0 the next cycle. Then replay -> ignored, because valid_digest is cleared.
REQ-040 The bench SHALL cover a new digest during SEND: a second hash_done rising edge mid-stream -> ignored; the digest in flight completes unchanged.
